// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into OUT_W-bit words with valid/ready.
// End of frame pads with 1-bits to a byte boundary and emits a tagged final partial word.
module huffman_bit_packer #(
  parameter int OUT_W   = 64,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_flush,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [3:0]         out_bytes,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int BUF_W  = OUT_W + MAX_LEN;
  localparam int FILL_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;

  state_t              state, state_next;
  logic [BUF_W-1:0]    bit_buf;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_padded;
  logic [FILL_W:0]     shamt;
  logic [LEN_W-1:0]    len_eff;
  logic [MAX_LEN-1:0]  code_masked;
  logic [BUF_W-1:0]    code_shifted;
  logic                out_free, word_ready, accept;
  logic                load_word, do_pad, do_drain;

  assign out_free   = !out_valid || out_ready;
  assign word_ready = fill >= FILL_W'(OUT_W);
  assign in_ready   = (state == RUN) && !word_ready;
  assign accept     = in_valid && in_ready;

  // Buffer is left-aligned with zeros below fill, so a new code is ORed in just under the valid bits.
  always_comb begin
    len_eff      = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
    code_masked  = in_code & ({MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_eff));
    shamt        = (FILL_W+1)'(BUF_W) - (FILL_W+1)'(fill) - (FILL_W+1)'(len_eff);
    code_shifted = BUF_W'(code_masked) << shamt;
    fill_padded  = (fill + FILL_W'(7)) & ~FILL_W'(7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    do_pad     = 1'b0;
    do_drain   = 1'b0;
    case (state)
      RUN: begin
        load_word = word_ready && out_free;
        if (accept && in_flush) state_next = PAD;
      end
      PAD: begin
        if (word_ready) begin
          load_word = out_free;
        end else begin
          do_pad     = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          do_drain   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Padding fills everything below fill with ones, so DRAIN can emit the top word directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf   <= '0;
      fill      <= '0;
      out_data  <= '0;
      out_bytes <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_word) begin
      out_data  <= bit_buf[BUF_W-1 -: OUT_W];
      out_bytes <= 4'(OUT_W / 8);
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      bit_buf   <= bit_buf << OUT_W;
      fill      <= fill - FILL_W'(OUT_W);
    end else if (do_drain) begin
      out_data  <= bit_buf[BUF_W-1 -: OUT_W];
      out_bytes <= 4'(fill >> 3);
      out_last  <= 1'b1;
      out_valid <= 1'b1;
      bit_buf   <= '0;
      fill      <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        bit_buf <= bit_buf | code_shifted;
        fill    <= fill + FILL_W'(len_eff);
      end else if (do_pad) begin
        bit_buf <= bit_buf | ({BUF_W{1'b1}} >> fill);
        fill    <= fill_padded;
      end
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: table of single-code frames plus multi-beat
// sequences checked against a reference bit queue.
module tb_huffman_bit_packer;
  localparam int OUT_W   = 64;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [MAX_LEN-1:0] in_code;
  logic [LEN_W-1:0]   in_len;
  logic               in_flush, in_valid, in_ready;
  logic [OUT_W-1:0]   out_data;
  logic [3:0]         out_bytes;
  logic               out_last, out_valid, out_ready;

  always #5 clk = ~clk;

  huffman_bit_packer #(.OUT_W(OUT_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_code(in_code), .in_len(in_len), .in_flush(in_flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct { logic [63:0] data; logic [3:0] bytes; logic last; } word_t;
  typedef struct { logic [31:0] code; logic [5:0] len; logic [63:0] exp_data; logic [3:0] exp_bytes; } vec_t;

  word_t cap_q[$];
  word_t exp_q[$];
  bit    ref_bits[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain bit queue, words cut every 64 bits, flush pads with ones.
  task automatic model_beat(logic [31:0] code, logic [5:0] len, bit flush);
    int n;
    n = (len > 6'd32) ? 32 : int'(len);
    for (int i = n - 1; i >= 0; i--) ref_bits.push_back(code[i]);
    while (ref_bits.size() >= 64) begin
      word_t w;
      w.data = '0;
      for (int i = 0; i < 64; i++) w.data[63-i] = ref_bits.pop_front();
      w.bytes = 4'd8;
      w.last  = 1'b0;
      exp_q.push_back(w);
    end
    if (flush) begin
      word_t w;
      int nb;
      while (ref_bits.size() % 8 != 0) ref_bits.push_back(1'b1);
      nb = ref_bits.size() / 8;
      w.data = '1;
      for (int i = 0; ref_bits.size() > 0; i++) w.data[63-i] = ref_bits.pop_front();
      w.bytes = 4'(nb);
      w.last  = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic send(logic [31:0] code, logic [5:0] len, bit flush);
    int t;
    t = 0;
    in_code = code; in_len = len; in_flush = flush; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    else model_beat(code, len, flush);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_flush = 1'b0;
  endtask

  task automatic get_word(output word_t w, output bit ok);
    int t;
    t = 0;
    while (cap_q.size() == 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    ok = cap_q.size() > 0;
    if (ok) w = cap_q.pop_front();
    else begin
      n_checks++;
      $display("FAIL word_timeout: got no output word, expected one");
    end
  endtask

  task automatic cmp_model(string tag, output word_t w);
    word_t e;
    bit ok;
    get_word(w, ok);
    if (ok) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s_extra: got word %h, expected none", tag, w.data);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_data"},  w.data,  e.data);
        check({tag, "_bytes"}, w.bytes, e.bytes);
        check({tag, "_last"},  w.last,  e.last);
      end
    end
  endtask

  // Capture accepted words and verify outputs stay frozen while stalled.
  logic [63:0] prev_data;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    if (rst_n && out_valid && out_ready) begin
      word_t w;
      w.data = out_data; w.bytes = out_bytes; w.last = out_last;
      cap_q.push_back(w);
    end
  end

  vec_t  vecs[8];
  word_t w;
  bit    ok;

  initial begin
    vecs[0] = '{32'h0000_0005,  6'd3,  64'hBFFF_FFFF_FFFF_FFFF, 4'd1};
    vecs[1] = '{32'h0000_0000,  6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 4'd0};
    vecs[2] = '{32'hDEAD_BEEF,  6'd32, 64'hDEAD_BEEF_FFFF_FFFF, 4'd4};
    vecs[3] = '{32'hFFFF_FF00,  6'd8,  64'h00FF_FFFF_FFFF_FFFF, 4'd1};
    vecs[4] = '{32'hFFFF_FE00,  6'd9,  64'h007F_FFFF_FFFF_FFFF, 4'd2};
    vecs[5] = '{32'h1234_5678,  6'd40, 64'h1234_5678_FFFF_FFFF, 4'd4};
    vecs[6] = '{32'h0000_0003,  6'd5,  64'h1FFF_FFFF_FFFF_FFFF, 4'd1};
    vecs[7] = '{32'h0000_0ABC,  6'd12, 64'hABCF_FFFF_FFFF_FFFF, 4'd2};

    rst_n = 1'b0; out_ready = 1'b1;
    in_code = '0; in_len = '0; in_flush = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_out_bytes", out_bytes, 0);
    check("rst_out_data",  out_data,  0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Two full codes make one word; valid appears one edge after the completing accept.
    send(32'hDEAD_BEEF, 6'd32, 1'b0);
    send(32'h0123_4567, 6'd32, 1'b0);
    check("t1_valid_latency", out_valid, 0);
    check("t1_in_ready_full", in_ready, 0);
    @(posedge clk);
    #1;
    check("t1_valid",  out_valid, 1);
    check("t1_data",   out_data,  64'hDEAD_BEEF_0123_4567);
    check("t1_bytes",  out_bytes, 8);
    check("t1_last",   out_last,  0);
    cmp_model("t1", w);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].code, vecs[i].len, 1'b1);
      get_word(w, ok);
      if (ok) begin
        check($sformatf("vec%0d_data", i),  w.data,  vecs[i].exp_data);
        check($sformatf("vec%0d_bytes", i), w.bytes, vecs[i].exp_bytes);
        check($sformatf("vec%0d_last", i),  w.last,  1);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
    end

    // 140 bits of 7-bit codes, then an empty flush beat.
    for (int i = 0; i < 20; i++) send(32'h55, 6'd7, 1'b0);
    send(32'h0, 6'd0, 1'b1);
    cmp_model("t3_w0", w);
    check("t3_w0_last", w.last, 0);
    cmp_model("t3_w1", w);
    cmp_model("t3_w2", w);
    check("t3_w2_bytes", w.bytes, 2);
    check("t3_w2_pad",   w.data[47:0], 48'hFFFF_FFFF_FFFF);

    // Stream ending on a word boundary yields a 0-byte last word.
    send(32'h0F0F_0F0F, 6'd32, 1'b0);
    send(32'hCAFE_F00D, 6'd32, 1'b0);
    send(32'h0, 6'd0, 1'b1);
    cmp_model("t4_w0", w);
    check("t4_w0_hand", w.data, 64'h0F0F_0F0F_CAFE_F00D);
    cmp_model("t4_w1", w);
    check("t4_w1_data",  w.data,  64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_w1_bytes", w.bytes, 0);
    check("t4_w1_last",  w.last,  1);

    // Backpressure: output stalls, input stops once a second word is pending.
    out_ready = 1'b0;
    send(32'h1111_2222, 6'd32, 1'b0);
    send(32'h3333_4444, 6'd32, 1'b0);
    send(32'h5555_6666, 6'd32, 1'b0);
    send(32'h7777_8888, 6'd32, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_in_ready_low", in_ready, 0);
    check("t5_valid_held",   out_valid, 1);
    check("t5_data_held",    out_data, 64'h1111_2222_3333_4444);
    out_ready = 1'b1;
    send(32'h9999_AAAA, 6'd32, 1'b0);
    send(32'hBBBB_CCCC, 6'd32, 1'b0);
    send(32'h0000_DDEE, 6'd16, 1'b1);
    cmp_model("t5_w0", w);
    cmp_model("t5_w1", w);
    cmp_model("t5_w2", w);
    cmp_model("t5_w3", w);
    check("t5_w3_bytes", w.bytes, 2);

    // Reset mid-frame with a stalled word and 40 buffered bits.
    out_ready = 1'b0;
    send(32'hAAAA_5555, 6'd32, 1'b0);
    send(32'h5555_AAAA, 6'd32, 1'b0);
    send(32'h0F0F_F0F0, 6'd32, 1'b0);
    send(32'h0000_00FF, 6'd8,  1'b0);
    check("t6_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data",  out_data,  0);
    check("t6_rst_bytes", out_bytes, 0);
    check("t6_rst_last",  out_last,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_bits.delete();
    exp_q.delete();
    cap_q.delete();
    out_ready = 1'b1;
    send(32'h1357_9BDF, 6'd32, 1'b0);
    send(32'h2468_ACE0, 6'd32, 1'b0);
    cmp_model("t6_w0", w);
    check("t6_w0_hand", w.data, 64'h1357_9BDF_2468_ACE0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_stale", cap_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
